mp_add_seq: RTL
===============

// Module: mp_add_seq
// PURPOSE
//  Multi-precision add/subtract sequencer. Time-multiplexes one W-bit rca
//  ripple-carry adder over W*WORDS-bit operands, one W-bit chunk per clock,
//  LSB chunk first. The carry is registered between chunks.
//  Sits between a requester (valid/ready command side) and a consumer
//  (valid/ready result side), for wide arithmetic without a wide adder.
// PARAMETERS
//  W      4  chunk width = width of the single rca instance (W >= 1)
//  WORDS  4  chunks per operand (WORDS >= 1); operand width is W*WORDS
// PORTS
//  clk          in   1        clock; all state updates on the rising edge
//  reset        in   1        synchronous reset, active-high
//  start_valid  in   1        command valid
//  start_ready  out  1        command ready; high only in IDLE
//  sub          in   1        0: y = a + b; 1: y = a - b; sampled at accept
//  a            in   W*WORDS  operand A, sampled at accept
//  b            in   W*WORDS  operand B, sampled at accept
//  res_valid    out  1        result valid; high only in DONE
//  res_ready    in   1        consumer ready
//  y            out  W*WORDS  result, modulo 2^(W*WORDS)
//  c_out        out  1        carry out of MSB chunk (sub: 1 = no borrow)
//  ovf          out  1        two's-complement signed overflow
// BEHAVIOUR
//  - Clock and reset: one clock; reset is synchronous and active-high.
//  - Reset: state=IDLE, idx=0, carry=0, y=0, c_out=0, ovf=0, res_valid=0,
//    start_ready=1 after the edge. Reset overrides all other inputs.
//  - FSM states: IDLE, RUN, DONE.
//    IDLE -> RUN on start_valid&start_ready. At this edge: latch a and b;
//      latch b_eff = sub ? ~b : b; set carry = sub; set idx = 0.
//    RUN: each edge feeds chunk idx of a and b_eff, plus carry, into the rca.
//      The rca sum is written into y[idx*W +: W]. carry <= rca c_out.
//      idx increments. On the edge for idx = WORDS-1: c_out <= rca c_out,
//      ovf is computed, and the state goes to DONE.
//    DONE -> IDLE on res_valid&res_ready.
//  - Latency: res_valid rises exactly WORDS edges after the accepting edge.
//    Throughput is one op per WORDS+2 cycles minimum. A DONE->IDLE bubble is
//    mandatory: start_ready is never high in the same cycle as res_valid.
//  - ovf = (a_msb == b_eff_msb) && (y_msb != a_msb); evaluated on the final
//    chunk.
//  - y, c_out and ovf hold stable from res_valid rising until the result
//    handshake, and also after it, until the next accept. Clearing y is
//    optional; RUN must overwrite every chunk.
//  - Backpressure: while res_ready=0 in DONE, stay in DONE indefinitely.
//  - start_valid outside IDLE: ignored; operands and sub are not resampled.
//  - res_ready outside DONE: ignored.
//  - Reset asserted in RUN or DONE: the operation is discarded and the reset
//    values above apply. No partial result is ever flagged valid.
//  - idx width is max(1, $clog2(WORDS)). For WORDS=1 the block completes in a
//    single RUN cycle.
//  - Data path: exactly one rca instance of width W. There is no W*WORDS-wide
//    adder.
// TESTING  (W=4, WORDS=4 unless noted)
//  1. sub=0, a=16'hFFFF, b=16'h0001 -> res_valid 4 edges after accept;
//     y=16'h0000, c_out=1, ovf=0.
//  2. sub=0, a=16'h7FFF, b=16'h0001 -> y=16'h8000, c_out=0, ovf=1.
//     Also a=16'h0FFF, b=16'h0001 -> y=16'h1000: carry crosses each boundary.
//  3. sub=1, a=16'h0005, b=16'h0007 -> y=16'hFFFE, c_out=0 (borrow), ovf=0.
//     Also sub=1, a=16'h8000, b=16'h0001 -> y=16'h7FFF, ovf=1.
//  4. Hold res_ready=0 for 10 cycles in DONE while driving start_valid=1 with
//     new operands -> y, c_out, ovf stable; start_ready=0; new command not
//     taken. It is accepted only in the IDLE cycle after the handshake.
//  5. Assert reset for one cycle on the 2nd RUN cycle -> next cycle
//     start_ready=1, res_valid=0, y=0. A following a=1, b=2 add gives y=3.
//  6. WORDS=1, W=8: a=8'hF0, b=8'h20 -> res_valid 1 edge after accept;
//     y=8'h10, c_out=1.

Source files
------------

// File: rtl/mp_add_seq.sv
// rtl/mp_add_seq.sv - multi-precision add/subtract sequencer over a single W-bit ripple-carry adder
//
// mp_add_seq_rca : W-bit ripple-carry adder, the only adder in the datapath.
//    i_a, i_b  in   W   addends
//    i_c       in   1   carry in
//    o_s       out  W   sum
//    o_c       out  1   carry out of bit W-1
//
// mp_add_seq : computes y = a + b or y = a - b over W*WORDS-bit operands,
//    one W-bit chunk per clock, LSB chunk first, carry registered between chunks.
//    clk          in   1        clock, rising edge
//    reset        in   1        synchronous reset, active-high
//    start_valid  in   1        command valid
//    start_ready  out  1        command ready (IDLE only)
//    sub          in   1        0: add, 1: subtract; sampled at accept
//    a, b         in   W*WORDS  operands, sampled at accept
//    res_valid    out  1        result valid (DONE only)
//    res_ready    in   1        consumer ready
//    y            out  W*WORDS  result modulo 2^(W*WORDS)
//    c_out        out  1        carry out of the MSB chunk (sub: 1 = no borrow)
//    ovf          out  1        two's-complement signed overflow

module mp_add_seq_rca #(
   parameter int W = 4
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_c,
   output logic [W-1:0] o_s,
   output logic         o_c
);

   logic [W:0] w_c;

   assign w_c[0] = i_c;

   for (genvar g = 0; g < W; g++) begin : g_fa
      assign o_s[g]     = i_a[g] ^ i_b[g] ^ w_c[g];
      assign w_c[g + 1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
   end

   assign o_c = w_c[W];

endmodule

module mp_add_seq #(
   parameter int W     = 4,
   parameter int WORDS = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start_valid,
   output logic               start_ready,
   input  logic               sub,
   input  logic [W*WORDS-1:0] a,
   input  logic [W*WORDS-1:0] b,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [W*WORDS-1:0] y,
   output logic               c_out,
   output logic               ovf
);

   localparam int AW = W * WORDS;
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_next_state;

   logic [AW-1:0]   r_a;
   logic [AW-1:0]   r_b;        // b already inverted for subtraction
   logic            r_carry;
   logic [IW-1:0]   r_idx;
   logic [AW-1:0]   r_y;
   logic            r_c_out;
   logic            r_ovf;

   logic            w_accept;
   logic            w_last;
   logic [W-1:0]    w_a_chunk;
   logic [W-1:0]    w_b_chunk;
   logic [W-1:0]    w_sum;
   logic            w_cout;

   assign w_accept = start_valid && (r_state == S_IDLE);
   assign w_last   = (r_idx == IW'(WORDS - 1));

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: if (start_valid)  w_next_state = S_RUN;
         S_RUN:  if (w_last)       w_next_state = S_DONE;
         S_DONE: if (res_ready)    w_next_state = S_IDLE;
         default:                  w_next_state = S_IDLE;
      endcase
   end

   // Output logic: ready and valid are mutually exclusive by construction,
   // which gives the mandatory bubble between a result and the next command.
   always_comb begin
      start_ready = 1'b0;
      res_valid   = 1'b0;
      case (r_state)
         S_IDLE:  start_ready = 1'b1;
         S_DONE:  res_valid   = 1'b1;
         default: ;
      endcase
   end

   // Chunk select. Compared against constant indices so a non-power-of-two
   // WORDS never produces an out-of-range part-select.
   always_comb begin
      w_a_chunk = '0;
      w_b_chunk = '0;
      for (int k = 0; k < WORDS; k++) begin
         if (r_idx == IW'(k)) begin
            w_a_chunk = r_a[k*W +: W];
            w_b_chunk = r_b[k*W +: W];
         end
      end
   end

   mp_add_seq_rca #(
      .W (W)
   ) u_rca (
      .i_a (w_a_chunk),
      .i_b (w_b_chunk),
      .i_c (r_carry),
      .o_s (w_sum),
      .o_c (w_cout)
   );

   // Datapath. Subtraction is a + ~b + 1: the +1 enters as the initial carry.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_idx   <= '0;
         r_y     <= '0;
         r_c_out <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_a     <= a;
                  r_b     <= sub ? ~b : b;
                  r_carry <= sub;
                  r_idx   <= '0;
               end
            end
            S_RUN: begin
               for (int k = 0; k < WORDS; k++) begin
                  if (r_idx == IW'(k)) begin
                     r_y[k*W +: W] <= w_sum;
                  end
               end
               r_carry <= w_cout;
               if (w_last) begin
                  r_idx   <= '0;
                  r_c_out <= w_cout;
                  // Operands of equal sign producing a result of the other sign
                  r_ovf   <= (r_a[AW-1] == r_b[AW-1]) && (w_sum[W-1] != r_a[AW-1]);
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign y     = r_y;
   assign c_out = r_c_out;
   assign ovf   = r_ovf;

endmodule
